// File: rtl/bus_sync_capture.sv
// Stability filter and FIFO placed after a bus synchronizer. A bus value is queued once it
// has held for `stable` cycles and differs from the last accepted value.
module bus_sync_capture #(
    parameter int unsigned sword   = 32,
    parameter int unsigned stable  = 2,
    parameter int unsigned depth   = 4,
    parameter int unsigned lgdepth = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [sword-1:0]   data_in,
    output logic [sword-1:0]   data_out,
    output logic               valid,
    input  logic               ready,
    output logic [lgdepth:0]   count,
    output logic               ovf,
    input  logic               clr_ovf
);

    localparam logic [3:0]         ScntMax    = 4'(stable);
    localparam logic [3:0]         ScntTarget = 4'(stable - 1);
    localparam logic [3:0]         ScntOne    = 4'(1);
    localparam logic [lgdepth:0]   CntFull    = (lgdepth + 1)'(depth);
    localparam logic [lgdepth:0]   CntOne     = (lgdepth + 1)'(1);
    localparam logic [lgdepth-1:0] PtrOne     = lgdepth'(1);

    logic [sword-1:0]   samp_q, samp_d;
    logic [sword-1:0]   committed_q, committed_d;
    logic [3:0]         scnt_q, scnt_d;
    logic [lgdepth-1:0] wptr_q, wptr_d;
    logic [lgdepth-1:0] rptr_q, rptr_d;
    logic [lgdepth:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [sword-1:0]   mem_q [depth];

    logic same;
    logic accept;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    // Filter: scnt counts consecutive repeats of samp and saturates at `stable`.
    always_comb begin
        same        = (data_in == samp_q);
        accept      = same && (scnt_q == ScntTarget) && (data_in != committed_q);
        samp_d      = data_in;
        scnt_d      = scnt_q;
        committed_d = committed_q;
        if (!same) begin
            scnt_d = '0;
        end else if (scnt_q < ScntMax) begin
            scnt_d = scnt_q + ScntOne;
        end
        // Committed updates even when the push is dropped, so a dropped value is not retried.
        if (accept) begin
            committed_d = data_in;
        end
    end

    always_comb begin
        full    = (count_q == CntFull);
        pop     = (count_q != '0) && ready;
        push_ok = accept && (!full || pop);
        drop    = accept && full && !pop;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (pop) begin
            rptr_d = rptr_q + PtrOne;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_q      <= '0;
            committed_q <= '0;
            scnt_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            samp_q      <= samp_d;
            committed_q <= committed_d;
            scnt_q      <= scnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible through valid.
    always_ff @(posedge CLK) begin
        if (!RST && push_ok) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    always_comb begin
        valid    = (count_q != '0);
        data_out = valid ? mem_q[rptr_q] : '0;
        count    = count_q;
        ovf      = ovf_q;
    end

endmodule
